// File: rtl/i2c_reg_bank.sv
// Pointer-addressed 8-bit register bank behind an I2C slave byte engine.
// Writable control registers below RO_BASE; status_in-sourced read-only registers from RO_BASE up.
module i2c_reg_bank #(
    parameter int N_REGS  = 16,
    parameter int RO_BASE = 12
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                ready,
    input  logic [7:0]          out_data,
    input  logic                out_ena,
    input  logic                master_rdreq,
    output logic [7:0]          master_data,
    input  logic [8*N_REGS-1:0] status_in,
    output logic [8*N_REGS-1:0] regs_flat,
    output logic                wr_stb,
    output logic [7:0]          wr_addr,
    output logic [7:0]          wr_data
);

    localparam int         AW        = $clog2(N_REGS);
    localparam logic [8:0] RO_BASE_W = 9'(RO_BASE);
    localparam logic [8:0] N_REGS_W  = 9'(N_REGS);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_PTR   = 3'd2;
    localparam logic [2:0] S_WDATA = 3'd3;
    localparam logic [2:0] S_RDATA = 3'd4;

    logic [2:0]    state;
    logic          ready_seen;
    logic [7:0]    ptr;
    logic [7:0]    regs [N_REGS];
    logic [AW-1:0] ptr_idx;
    logic          ptr_rw;
    logic          ptr_in_map;
    logic [7:0]    rd_val;

    assign ptr_idx    = ptr[AW-1:0];
    assign ptr_rw     = {1'b0, ptr} < RO_BASE_W;
    assign ptr_in_map = {1'b0, ptr} < N_REGS_W;

    // NOTE: every variable gets a default before the ifs, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        rd_val = 8'hFF;
        if (ptr_rw)
            rd_val = regs[ptr_idx];
        else if (ptr_in_map)
            rd_val = status_in[{ptr_idx, 3'b000} +: 8];
    end

    // Read-only slots are never written, so they read back as zero here.
    always_comb begin
        regs_flat = '0;
        for (int i = 0; i < RO_BASE; i++)
            regs_flat[8*i +: 8] = regs[i];
    end

    // NOTE: clocked state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= S_IDLE;
            ready_seen  <= 1'b0;
            ptr         <= 8'h00;
            master_data <= 8'h00;
            wr_stb      <= 1'b0;
            wr_addr     <= 8'h00;
            wr_data     <= 8'h00;
            // NOTE: the register array is reset because regs_flat must read all-zero straight out of reset.
            for (int i = 0; i < N_REGS; i++)
                regs[i] <= 8'h00;
        end else begin
            wr_stb      <= 1'b0;
            master_data <= rd_val;
            if (ready) begin
                state      <= S_IDLE;
                ready_seen <= 1'b1;
            end else begin
                case (state)
                    // A transfer already in flight when reset released is ignored until STOP.
                    S_IDLE: if (ready_seen) state <= S_ADDR;
                    S_ADDR: begin
                        if (out_ena)
                            state <= out_data[0] ? S_RDATA : S_PTR;
                    end
                    S_PTR: begin
                        if (out_ena) begin
                            ptr   <= out_data;
                            state <= S_WDATA;
                        end
                    end
                    S_WDATA: begin
                        if (out_ena) begin
                            if (ptr_rw) begin
                                regs[ptr_idx] <= out_data;
                                wr_stb        <= 1'b1;
                                wr_addr       <= ptr;
                                wr_data       <= out_data;
                            end
                            ptr <= ptr + 8'd1;
                        end
                    end
                    S_RDATA: begin
                        if (master_rdreq)
                            ptr <= ptr + 8'd1;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_reg_bank.sv
// Self-checking bench for i2c_reg_bank: scoreboard queues for writes (wr_stb) and reads (master_rdreq),
// plus per-scenario inline checks of pointer, register image and reset behaviour.
module tb_i2c_reg_bank;

    localparam int N_REGS  = 16;
    localparam int RO_BASE = 12;

    logic                clk = 1'b0;
    logic                n_rst;
    logic                ready;
    logic [7:0]          out_data;
    logic                out_ena;
    logic                master_rdreq;
    logic [7:0]          master_data;
    logic [8*N_REGS-1:0] status_in;
    logic [8*N_REGS-1:0] regs_flat;
    logic                wr_stb;
    logic [7:0]          wr_addr;
    logic [7:0]          wr_data;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_exp_t;

    wr_exp_t    wr_q[$];
    logic [7:0] rd_q[$];
    wr_exp_t    mon_w;
    logic [7:0] mon_r;
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] m_regs [N_REGS];
    logic [7:0] m_ptr;

    always #5 clk = ~clk;

    i2c_reg_bank #(.N_REGS(N_REGS), .RO_BASE(RO_BASE)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .ready        (ready),
        .out_data     (out_data),
        .out_ena      (out_ena),
        .master_rdreq (master_rdreq),
        .master_data  (master_data),
        .status_in    (status_in),
        .regs_flat    (regs_flat),
        .wr_stb       (wr_stb),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data)
    );

    // Write scoreboard: every wr_stb cycle must match the next expected write.
    always @(negedge clk) begin
        if (n_rst === 1'b1 && wr_stb === 1'b1) begin
            n_checks++;
            if (wr_q.size() == 0) begin
                n_fail++;
                $display("FAIL wr_stb_unexpected: got addr=%h data=%h, expected no write", wr_addr, wr_data);
            end else begin
                mon_w = wr_q.pop_front();
                if ({wr_addr, wr_data} !== {mon_w.addr, mon_w.data}) begin
                    n_fail++;
                    $display("FAIL wr_port: got addr=%h data=%h, expected addr=%h data=%h",
                             wr_addr, wr_data, mon_w.addr, mon_w.data);
                end
                n_checks++;
                if (regs_flat[8*mon_w.addr +: 8] !== mon_w.data) begin
                    n_fail++;
                    $display("FAIL wr_regs_flat: reg%0d got %h, expected %h",
                             mon_w.addr, regs_flat[8*mon_w.addr +: 8], mon_w.data);
                end
            end
        end
    end

    // Read scoreboard: the byte on master_data when rdreq fires is the byte that was sent.
    always @(negedge clk) begin
        if (n_rst === 1'b1 && master_rdreq === 1'b1) begin
            n_checks++;
            if (rd_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_unexpected: got master_data=%h with no expected read", master_data);
            end else begin
                mon_r = rd_q.pop_front();
                if (master_data !== mon_r) begin
                    n_fail++;
                    $display("FAIL rd_data: got master_data=%h, expected %h", master_data, mon_r);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] exp_rd(input logic [7:0] p);
        if (p < RO_BASE) return m_regs[p[3:0]];
        if (p < N_REGS)  return status_in[8*p +: 8];
        return 8'hFF;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_xfer();
        ready = 1'b0;
        tick();
        tick();
    endtask

    task automatic stop_xfer();
        ready = 1'b1;
        tick();
        tick();
    endtask

    task automatic strobe(input logic [7:0] b);
        out_data = b;
        out_ena  = 1'b1;
        tick();
        out_ena  = 1'b0;
        tick();
    endtask

    task automatic send_addr(input logic rd);
        strobe({7'h42, rd});
    endtask

    task automatic send_ptr(input logic [7:0] p);
        strobe(p);
        m_ptr = p;
    endtask

    task automatic send_wdata(input logic [7:0] d);
        if (m_ptr < RO_BASE) begin
            wr_q.push_back({m_ptr, d});
            m_regs[m_ptr[3:0]] = d;
        end
        m_ptr++;
        strobe(d);
    endtask

    task automatic rd_req();
        rd_q.push_back(exp_rd(m_ptr));
        master_rdreq = 1'b1;
        tick();
        master_rdreq = 1'b0;
        m_ptr++;
        tick();
    endtask

    task automatic set_ptr(input logic [7:0] p);
        start_xfer();
        send_addr(1'b0);
        send_ptr(p);
        stop_xfer();
    endtask

    task automatic test_reset();
        n_rst = 1'b0; ready = 1'b1; out_ena = 1'b0; master_rdreq = 1'b0; out_data = 8'h00;
        status_in = '0;
        status_in[8*12 +: 8] = 8'h3C;
        status_in[8*13 +: 8] = 8'hC3;
        status_in[8*14 +: 8] = 8'h5A;
        status_in[8*15 +: 8] = 8'hA5;
        for (int i = 0; i < N_REGS; i++) m_regs[i] = 8'h00;
        m_ptr = 8'h00;
        repeat (3) tick();
        n_checks++;
        if (master_data !== 8'h00) begin n_fail++; $display("FAIL rst_master_data: got %h, expected 00", master_data); end
        n_checks++;
        if (regs_flat !== '0) begin n_fail++; $display("FAIL rst_regs_flat: got %h, expected 0", regs_flat); end
        n_checks++;
        if (wr_stb !== 1'b0) begin n_fail++; $display("FAIL rst_wr_stb: got %b, expected 0", wr_stb); end
        n_checks++;
        if ({wr_addr, wr_data} !== 16'h0000) begin n_fail++; $display("FAIL rst_wr_regs: got %h/%h, expected 00/00", wr_addr, wr_data); end
        n_rst = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (master_data !== 8'h00 || regs_flat !== '0 || wr_stb !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_release: got md=%h stb=%b, expected md=00 stb=0 regs 0", master_data, wr_stb);
        end
        n_checks++;
        if (dut.ptr !== 8'h00) begin n_fail++; $display("FAIL rst_ptr: got %h, expected 00", dut.ptr); end
    endtask

    task automatic test_write_burst();
        start_xfer();
        send_addr(1'b0);
        send_ptr(8'h02);
        send_wdata(8'hAA);
        send_wdata(8'h55);
        stop_xfer();
        n_checks++;
        if (regs_flat[8*2 +: 16] !== 16'h55AA) begin n_fail++; $display("FAIL burst_regs: got reg3:reg2=%h, expected 55AA", regs_flat[8*2 +: 16]); end
        n_checks++;
        if (dut.ptr !== 8'h04) begin n_fail++; $display("FAIL burst_ptr: got %h, expected 04", dut.ptr); end
        n_checks++;
        if (wr_q.size() != 0) begin n_fail++; $display("FAIL burst_pending: got %0d writes missing, expected 0", wr_q.size()); end
        n_checks++;
        if ({wr_addr, wr_data} !== 16'h0355) begin n_fail++; $display("FAIL burst_hold: got %h/%h, expected 03/55", wr_addr, wr_data); end
    endtask

    task automatic test_ptr_read();
        set_ptr(8'h03);
        n_checks++;
        if (dut.ptr !== 8'h03) begin n_fail++; $display("FAIL ptrrd_ptr_set: got %h, expected 03", dut.ptr); end
        start_xfer();
        send_addr(1'b1);
        rd_req();
        rd_req();
        stop_xfer();
        n_checks++;
        if (dut.ptr !== 8'h05) begin n_fail++; $display("FAIL ptrrd_ptr_end: got %h, expected 05", dut.ptr); end
        n_checks++;
        if (rd_q.size() != 0) begin n_fail++; $display("FAIL ptrrd_pending: got %0d reads unchecked, expected 0", rd_q.size()); end
    endtask

    task automatic test_ro();
        start_xfer();
        send_addr(1'b0);
        send_ptr(8'h0C);
        send_wdata(8'h99);
        stop_xfer();
        n_checks++;
        if (dut.ptr !== 8'h0D) begin n_fail++; $display("FAIL ro_ptr: got %h, expected 0d", dut.ptr); end
        n_checks++;
        if (regs_flat[8*12 +: 8] !== 8'h00) begin n_fail++; $display("FAIL ro_flat: got %h, expected 00", regs_flat[8*12 +: 8]); end
        set_ptr(8'h0B);
        start_xfer();
        send_addr(1'b1);
        rd_req();
        rd_req();
        rd_req();
        stop_xfer();
        status_in[8*14 +: 8] = 8'h77;
        tick();
        start_xfer();
        send_addr(1'b1);
        rd_req();
        rd_req();
        rd_req();
        stop_xfer();
        n_checks++;
        if (dut.ptr !== 8'h11 || rd_q.size() != 0) begin
            n_fail++;
            $display("FAIL ro_read_end: got ptr=%h pending=%0d, expected ptr=11 pending=0", dut.ptr, rd_q.size());
        end
    endtask

    task automatic test_wrap();
        start_xfer();
        send_addr(1'b0);
        send_ptr(8'h0B);
        send_wdata(8'h77);
        send_wdata(8'h88);
        stop_xfer();
        n_checks++;
        if (regs_flat[8*11 +: 16] !== 16'h0077) begin n_fail++; $display("FAIL edge_ro_base: got reg12:reg11=%h, expected 0077", regs_flat[8*11 +: 16]); end
        start_xfer();
        send_addr(1'b0);
        send_ptr(8'hFF);
        send_wdata(8'h11);
        stop_xfer();
        n_checks++;
        if (dut.ptr !== 8'h00) begin n_fail++; $display("FAIL wrap_ptr: got %h, expected 00", dut.ptr); end
        n_checks++;
        if ({wr_addr, wr_data} !== 16'h0B77) begin n_fail++; $display("FAIL wrap_hold: got %h/%h, expected 0b/77", wr_addr, wr_data); end
        set_ptr(8'h20);
        start_xfer();
        send_addr(1'b1);
        rd_req();
        stop_xfer();
        set_ptr(8'hFF);
        start_xfer();
        send_addr(1'b1);
        rd_req();
        rd_req();
        stop_xfer();
        n_checks++;
        if (dut.ptr !== 8'h01 || rd_q.size() != 0) begin
            n_fail++;
            $display("FAIL wrap_read: got ptr=%h pending=%0d, expected ptr=01 pending=0", dut.ptr, rd_q.size());
        end
    endtask

    task automatic test_abort();
        start_xfer();
        send_addr(1'b0);
        send_ptr(8'h05);
        stop_xfer();
        n_checks++;
        if (dut.state !== 3'd0 || dut.ptr !== 8'h05) begin
            n_fail++;
            $display("FAIL abort_idle: got state=%0d ptr=%h, expected 0/05", dut.state, dut.ptr);
        end
        start_xfer();
        send_addr(1'b0);
        send_ptr(8'h07);
        ready    = 1'b1;
        out_data = 8'h42;
        out_ena  = 1'b1;
        tick();
        out_ena  = 1'b0;
        tick();
        strobe(8'h84);
        strobe(8'h03);
        strobe(8'h66);
        n_checks++;
        if (dut.ptr !== 8'h07 || regs_flat[8*7 +: 8] !== 8'h00) begin
            n_fail++;
            $display("FAIL abort_priority: got ptr=%h reg7=%h, expected 07/00", dut.ptr, regs_flat[8*7 +: 8]);
        end
        start_xfer();
        send_addr(1'b0);
        send_ptr(8'h06);
        send_wdata(8'hE1);
        stop_xfer();
        n_checks++;
        if (regs_flat[8*5 +: 16] !== 16'hE100) begin n_fail++; $display("FAIL abort_next: got reg6:reg5=%h, expected e100", regs_flat[8*5 +: 16]); end
    endtask

    task automatic test_back_to_back();
        start_xfer();
        send_addr(1'b0);
        send_ptr(8'h08);
        for (int i = 1; i <= 3; i++) begin
            out_data = 8'(16 * i);
            wr_q.push_back({m_ptr, out_data});
            m_regs[m_ptr[3:0]] = out_data;
            m_ptr++;
            out_ena = 1'b1;
            tick();
        end
        out_ena = 1'b0;
        tick();
        stop_xfer();
        n_checks++;
        if (regs_flat[8*8 +: 24] !== 24'h302010) begin n_fail++; $display("FAIL b2b_regs: got %h, expected 302010", regs_flat[8*8 +: 24]); end
        n_checks++;
        if (dut.ptr !== 8'h0B || wr_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_ptr: got ptr=%h pending=%0d, expected 0b/0", dut.ptr, wr_q.size());
        end
    endtask

    task automatic test_reset_mid();
        start_xfer();
        send_addr(1'b0);
        send_ptr(8'h01);
        send_wdata(8'h5E);
        #2;
        n_rst = 1'b0;
        #1;
        for (int i = 0; i < N_REGS; i++) m_regs[i] = 8'h00;
        m_ptr = 8'h00;
        n_checks++;
        if (regs_flat !== '0 || master_data !== 8'h00 || wr_stb !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_async: got md=%h stb=%b flat=%h, expected all zero", master_data, wr_stb, regs_flat);
        end
        n_checks++;
        if ({wr_addr, wr_data} !== 16'h0000 || dut.ptr !== 8'h00) begin
            n_fail++;
            $display("FAIL midrst_regs: got %h/%h ptr=%h, expected 00/00 ptr=00", wr_addr, wr_data, dut.ptr);
        end
        tick();
        n_rst = 1'b1;
        tick();
        strobe(8'h84);
        strobe(8'h01);
        strobe(8'h77);
        n_checks++;
        if (regs_flat !== '0 || dut.state !== 3'd0) begin
            n_fail++;
            $display("FAIL midrst_wait_ready: got state=%0d flat=%h, expected state 0 and zero regs", dut.state, regs_flat);
        end
        stop_xfer();
        start_xfer();
        send_addr(1'b1);
        rd_req();
        stop_xfer();
        n_checks++;
        if (rd_q.size() != 0 || dut.ptr !== 8'h01) begin
            n_fail++;
            $display("FAIL midrst_resume: got ptr=%h pending=%0d, expected 01/0", dut.ptr, rd_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_ptr_read();
        test_ro();
        test_wrap();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
